// File: rtl/led_sequencer_pkg.sv
// led_sequencer shared definitions: register map, modes, CTRL layout
// and the byte-lane merge used by the bus slaves.
package led_sequencer_pkg;

    localparam logic [1:0] ADDR_PATTERN = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTL   = 2'd2;
    localparam logic [1:0] MODE_ROTR   = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_W        = 3;

    typedef enum logic {
        ST_HOLD,
        ST_RUN
    } run_state_t;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] m;
        m = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m[8*i +: 8] = new_v[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running period counter; tick fires on the cycle
// the count reaches the period, giving one tick every period+1 cycles.
module led_tick_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        clear,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] cnt;

    assign tick = run && (cnt >= period);

    // Count while running; a clear always wins over the tick wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? 32'd0 : cnt + 32'd1;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: bus-mapped LED pattern engine driving active-low pins
// with static, blink and rotate displays.
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter logic [31:0] PERIOD_RST = 32'd25_000_000,
    parameter int          TICK_CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [1:0]  addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] WD,
    output logic [31:0] O,
    output logic [31:0] LEDLight
);

    logic [31:0]           pattern;
    logic [31:0]           display;
    logic [CTRL_W-1:0]     ctrl;
    logic [31:0]           period;
    logic                  phase;
    logic [TICK_CNT_W-1:0] ticks;

    logic        wr;
    logic        wr_pat;
    logic        wr_ctrl;
    logic        wr_per;
    logic [31:0] old_word;
    logic [31:0] merged;
    logic [1:0]  mode;
    logic        tick;
    logic        clear;
    run_state_t  state;

    assign wr      = WE && (byteen != 4'd0);
    assign wr_pat  = wr && (addr == ADDR_PATTERN);
    assign wr_ctrl = wr && (addr == ADDR_CTRL);
    assign wr_per  = wr && (addr == ADDR_PERIOD);
    assign clear   = wr_pat || wr_ctrl || wr_per;
    assign mode    = ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB];
    assign merged  = byte_merge(old_word, WD, byteen);

    // Current register contents at the addressed word, for lane merging.
    always_comb begin
        old_word = '0;
        unique case (addr)
            ADDR_PATTERN: old_word = pattern;
            ADDR_CTRL:    old_word = {{(32-CTRL_W){1'b0}}, ctrl};
            ADDR_PERIOD:  old_word = period;
            default:      old_word = '0;
        endcase
    end

    // Run/hold decision follows CTRL every cycle.
    always_comb begin
        state = ST_HOLD;
        if (ctrl[CTRL_EN] && (mode != MODE_STATIC)) state = ST_RUN;
    end

    led_tick_gen u_tick (
        .clk    (clk),
        .reset  (reset),
        .run    (state == ST_RUN),
        .clear  (clear),
        .period (period),
        .tick   (tick)
    );

    // Software-visible configuration registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern <= '0;
            ctrl    <= '0;
            period  <= PERIOD_RST;
        end else begin
            if (wr_pat)  pattern <= merged;
            if (wr_ctrl) ctrl    <= merged[CTRL_W-1:0];
            if (wr_per)  period  <= merged;
        end
    end

    // Display engine: tick effects first, bus write side effects override.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            display <= '0;
            phase   <= 1'b0;
            ticks   <= '0;
        end else begin
            if (tick) begin
                ticks <= ticks + 1'b1;
                unique case (mode)
                    MODE_BLINK: phase   <= ~phase;
                    MODE_ROTL:  display <= {display[30:0], display[31]};
                    MODE_ROTR:  display <= {display[0], display[31:1]};
                    default:    ;
                endcase
            end
            if (wr_pat) begin
                display <= merged;
                phase   <= 1'b0;
                ticks   <= '0;
            end
            if (wr_ctrl) phase <= 1'b0;
        end
    end

    // Pins are active-low; blink off-phase blanks the display.
    assign LEDLight = ~(((mode == MODE_BLINK) && phase) ? 32'd0 : display);

    // Read mux.
    always_comb begin
        O = '0;
        unique case (addr)
            ADDR_PATTERN: O = pattern;
            ADDR_CTRL:    O = {{(32-CTRL_W){1'b0}}, ctrl};
            ADDR_PERIOD:  O = period;
            ADDR_STATUS:  O = 32'(ticks);
            default:      O = '0;
        endcase
    end

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed stimulus with a behavioural reference
// model compared every cycle, plus literal expectations.
module tb_led_sequencer;

    localparam logic [31:0] PERIOD_RST = 32'd25_000_000;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [1:0]  addr;
    logic [3:0]  byteen;
    logic [31:0] WD;
    logic [31:0] O;
    logic [31:0] LEDLight;

    int n_pass;
    int n_total;
    bit check_en;

    led_sequencer #(
        .PERIOD_RST (PERIOD_RST),
        .TICK_CNT_W (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .WE       (WE),
        .addr     (addr),
        .byteen   (byteen),
        .WD       (WD),
        .O        (O),
        .LEDLight (LEDLight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_pat;
    logic [31:0] m_disp;
    logic [2:0]  m_ctrl;
    logic [31:0] m_per;
    logic        m_phase;
    logic [31:0] m_ticks;
    logic [31:0] m_elapsed;
    logic        m_running;
    logic        m_fire;
    logic [31:0] m_word;

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rotate(input logic [31:0] d,
                                           input int left);
        logic [63:0] dd;
        int k;
        dd = {d, d};
        k = ((left % 32) + 32) % 32;
        return dd[63:32] << k | d >> ((32 - k) % 32) & ((k == 0) ? 32'd0 : 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] exp_led();
        return ~(((m_ctrl[2:1] == 2'd1) && m_phase) ? 32'd0 : m_disp);
    endfunction

    function automatic logic [31:0] exp_o(input logic [1:0] a);
        case (a)
            2'd0:    return m_pat;
            2'd1:    return {29'd0, m_ctrl};
            2'd2:    return m_per;
            default: return m_ticks;
        endcase
    endfunction

    assign m_running = m_ctrl[0] && (m_ctrl[2:1] != 2'd0);
    assign m_fire    = m_running && (m_elapsed >= m_per);

    always_comb begin
        m_word = 32'd0;
        case (addr)
            2'd0:    m_word = m_pat;
            2'd1:    m_word = {29'd0, m_ctrl};
            2'd2:    m_word = m_per;
            default: m_word = 32'd0;
        endcase
    end

    // Model: a tick happens after period+1 running cycles; writes override.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pat     <= 32'd0;
            m_disp    <= 32'd0;
            m_ctrl    <= 3'd0;
            m_per     <= PERIOD_RST;
            m_phase   <= 1'b0;
            m_ticks   <= 32'd0;
            m_elapsed <= 32'd0;
        end else begin
            if (m_fire) begin
                m_ticks   <= m_ticks + 32'd1;
                m_elapsed <= 32'd0;
                if (m_ctrl[2:1] == 2'd1) m_phase <= ~m_phase;
                if (m_ctrl[2:1] == 2'd2) m_disp  <= rotate(m_disp, 1);
                if (m_ctrl[2:1] == 2'd3) m_disp  <= rotate(m_disp, -1);
            end else if (m_running) begin
                m_elapsed <= m_elapsed + 32'd1;
            end
            if (WE && byteen != 4'd0) begin
                if (addr == 2'd0) begin
                    m_pat     <= merge(m_word, WD, byteen);
                    m_disp    <= merge(m_word, WD, byteen);
                    m_phase   <= 1'b0;
                    m_ticks   <= 32'd0;
                    m_elapsed <= 32'd0;
                end
                if (addr == 2'd1) begin
                    m_ctrl    <= merge(m_word, WD, byteen) & 32'h7;
                    m_phase   <= 1'b0;
                    m_elapsed <= 32'd0;
                end
                if (addr == 2'd2) begin
                    m_per     <= merge(m_word, WD, byteen);
                    m_elapsed <= 32'd0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_led", LEDLight, exp_led());
            chk("model_o", O, exp_o(addr));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [3:0] be,
                      input logic [31:0] d);
        WE = 1'b1; addr = a; byteen = be; WD = d;
        @(posedge clk); #1;
        WE = 1'b0; byteen = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        n_pass = 0; n_total = 0; check_en = 1'b0;
        reset = 1'b0; WE = 1'b0; addr = 2'd0; byteen = 4'd0; WD = 32'd0;

        // Reset
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check_en = 1'b1;
        chk("rst_led", LEDLight, 32'hFFFF_FFFF);
        addr = 2'd2; #1 chk("rst_period", O, PERIOD_RST);
        addr = 2'd3; #1 chk("rst_status", O, 32'd0);
        idle(1);

        // Byte lanes
        wr(2'd0, 4'b1111, 32'hAABB_CCDD);
        wr(2'd0, 4'b0101, 32'h1122_3344);
        addr = 2'd0; #1;
        chk("lane_o", O, 32'hAA22_CC44);
        chk("lane_led", LEDLight, 32'h55DD_33BB);
        idle(1);

        // Rotate left
        wr(2'd0, 4'hF, 32'h0000_0001);
        wr(2'd2, 4'hF, 32'd3);
        wr(2'd1, 4'hF, 32'b101);
        idle(4);
        chk("rotl_1", LEDLight, ~32'h0000_0002);
        idle(4);
        chk("rotl_2", LEDLight, ~32'h0000_0004);
        idle(120);
        chk("rotl_wrap", LEDLight, ~32'h0000_0001);
        addr = 2'd3; #1 chk("rotl_ticks", O, 32'd32);
        idle(1);

        // Blink
        wr(2'd1, 4'hF, 32'd0);
        wr(2'd0, 4'hF, 32'hF0F0_F0F0);
        wr(2'd2, 4'hF, 32'd0);
        wr(2'd1, 4'hF, 32'b011);
        chk("blink_on", LEDLight, 32'h0F0F_0F0F);
        idle(1);
        chk("blink_off", LEDLight, 32'hFFFF_FFFF);
        idle(1);
        chk("blink_on2", LEDLight, 32'h0F0F_0F0F);
        wr(2'd1, 4'hF, 32'b010);
        chk("blink_frz", LEDLight, 32'h0F0F_0F0F);
        idle(5);
        chk("blink_frz2", LEDLight, 32'h0F0F_0F0F);

        // Collision of PATTERN write with a rotr tick
        wr(2'd1, 4'hF, 32'd0);
        wr(2'd0, 4'hF, 32'h0000_0001);
        wr(2'd2, 4'hF, 32'd2);
        wr(2'd1, 4'hF, 32'b111);
        idle(2);
        wr(2'd0, 4'hF, 32'h8000_0000);
        chk("coll_led", LEDLight, 32'h7FFF_FFFF);
        addr = 2'd3; #1 chk("coll_ticks", O, 32'd0);
        addr = 2'd0; #1 chk("coll_pat", O, 32'h8000_0000);
        idle(2);
        chk("coll_hold", LEDLight, 32'h7FFF_FFFF);
        idle(1);
        chk("coll_shift", LEDLight, 32'hBFFF_FFFF);

        // Async reset mid-rotation
        wr(2'd1, 4'hF, 32'b101);
        idle(5);
        addr = 2'd2;
        #2 reset = 1'b0;
        #1;
        chk("arst_led", LEDLight, 32'hFFFF_FFFF);
        chk("arst_period", O, PERIOD_RST);
        @(posedge clk); #1;
        addr = 2'd0; #1 chk("arst_pat", O, 32'd0);
        addr = 2'd1; #1 chk("arst_ctrl", O, 32'd0);
        addr = 2'd3; #1 chk("arst_status", O, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        idle(4);
        chk("post_rst_led", LEDLight, 32'hFFFF_FFFF);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
